vec_max_bcast: RTL and testbench

Streaming max-reduction and broadcast stage that sits directly upstream of the packed 4-lane 16-bit subtractor in the softmax path. It accepts one vector of LEN 64-bit words, each holding four signed 16-bit lanes, and buffers it while tracking the global maximum over all lanes. It then replays the buffered words together with the maximum replicated into all four lanes. The subtractor's `a` and `b` inputs then produce x − max for every element.

---
 rtl/vmax_pkg.sv | 15 +
 rtl/vmax_lane_reduce.sv | 22 ++
 rtl/vec_max_bcast.sv | 102 ++++++++++
 tb/tb_vec_max_bcast.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/vmax_pkg.sv
// Shared constants and types for the softmax max-reduce/broadcast stage.
package vmax_pkg;
    localparam int LANES  = 4;
    localparam int LANE_W = 16;
    localparam int VEC_W  = LANES * LANE_W;
    localparam int LANE_SEL_W = $clog2(LANES);
    localparam logic signed [LANE_W-1:0] MIN_VAL = 16'sh8000;

    typedef logic signed [LANE_W-1:0] lane_t;

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;
endpackage

// File: rtl/vmax_lane_reduce.sv
// Combinational signed max across the four lanes of one word; lowest lane wins ties.
module vmax_lane_reduce
    import vmax_pkg::*;
(
    input  logic [LANES-1:0][LANE_W-1:0] word,
    output lane_t                        max_val,
    output logic [LANE_SEL_W-1:0]        max_lane
);

    always_comb begin
        max_val  = lane_t'(word[0]);
        max_lane = '0;
        // strict compare keeps the earliest lane on equal values
        for (int k = 1; k < LANES; k++) begin
            if (lane_t'(word[k]) > max_val) begin
                max_val  = lane_t'(word[k]);
                max_lane = LANE_SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/vec_max_bcast.sv
// Buffers one LEN-word vector while tracking its global lane max, then replays it with the max broadcast.
// Optional argmax output enabled by defining VEC_MAX_BCAST_ARGMAX_EN.
module vec_max_bcast
    import vmax_pkg::*;
#(
    parameter int LEN = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [VEC_W-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [VEC_W-1:0] out_data,
    output logic [VEC_W-1:0] out_max,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last
`ifdef VEC_MAX_BCAST_ARGMAX_EN
    ,
    output logic [$clog2(LEN*LANES)-1:0] out_idx
`endif
);

    localparam int CW = $clog2(LEN);

    state_t              state, state_nxt;
    logic [CW-1:0]       wr_cnt, rd_cnt;
    lane_t               max_r;
    logic [VEC_W-1:0]    buf_mem [LEN];
    lane_t               red_max;
    logic [LANE_SEL_W-1:0] red_lane;
    logic                in_fire, out_fire, wr_last, rd_last;

    vmax_lane_reduce u_reduce (
        .word     (in_data),
        .max_val  (red_max),
        .max_lane (red_lane)
    );

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign wr_last  = (wr_cnt == CW'(LEN - 1));
    assign rd_last  = (rd_cnt == CW'(LEN - 1));

    // Handshake outputs come from the state register alone.
    always_comb begin
        state_nxt = state;
        in_ready  = (state == COLLECT);
        out_valid = (state == EMIT);
        case (state)
            COLLECT: if (in_fire && wr_last) state_nxt = EMIT;
            EMIT:    if (out_fire && rd_last) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= COLLECT;
            wr_cnt <= '0;
            rd_cnt <= '0;
            max_r  <= '0;
        end else begin
            state <= state_nxt;
            if (in_fire) begin
                wr_cnt <= wr_last ? '0 : wr_cnt + CW'(1);
                // word 0 seeds the max so a previous vector never leaks in
                if (wr_cnt == '0 || red_max > max_r)
                    max_r <= red_max;
            end
            if (out_fire)
                rd_cnt <= rd_last ? '0 : rd_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire)
            buf_mem[wr_cnt] <= in_data;
    end

    assign out_data = out_valid ? buf_mem[rd_cnt] : '0;
    assign out_max  = out_valid ? {LANES{max_r}} : '0;
    assign out_last = out_valid && rd_last;

`ifdef VEC_MAX_BCAST_ARGMAX_EN
    logic [$clog2(LEN*LANES)-1:0] idx_r;

    // flat index word*LANES+lane is just the concatenation since LANES is a power of two
    always_ff @(posedge clk) begin
        if (rst)
            idx_r <= '0;
        else if (in_fire && (wr_cnt == '0 || red_max > max_r))
            idx_r <= {wr_cnt, red_lane};
    end

    assign out_idx = out_valid ? idx_r : '0;
`else
    logic unused_lane;
    assign unused_lane = ^red_lane;
`endif

endmodule

// File: tb/tb_vec_max_bcast.sv
// Directed self-checking bench for vec_max_bcast (LEN=8).
module tb_vec_max_bcast;
    localparam int LEN = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_data;
    logic [63:0] out_max;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
`ifdef VEC_MAX_BCAST_ARGMAX_EN
    logic [4:0]  out_idx;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vec_max_bcast #(.LEN(LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_max   (out_max),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
`ifdef VEC_MAX_BCAST_ARGMAX_EN
        ,
        .out_idx   (out_idx)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [15:0] v3, v2, v1, v0);
        return {v3, v2, v1, v0};
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, ".in_ready"},  64'(in_ready),  64'd1);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, ".out_data"},  out_data,       64'd0);
        chk({tag, ".out_max"},   out_max,        64'd0);
        chk({tag, ".out_last"},  64'(out_last),  64'd0);
`ifdef VEC_MAX_BCAST_ARGMAX_EN
        chk({tag, ".out_idx"},   64'(out_idx),   64'd0);
`endif
    endtask

    task automatic send_vec(input string tag, input logic [63:0] w [LEN]);
        for (int i = 0; i < LEN; i++) begin
            @(negedge clk);
            chk($sformatf("%s.in_ready[%0d]", tag, i), 64'(in_ready), 64'd1);
            chk($sformatf("%s.no_out[%0d]", tag, i), 64'(out_valid), 64'd0);
            in_valid = 1'b1;
            in_data  = w[i];
        end
    endtask

    // Drains one vector; garbage is held on in_valid throughout to exercise hold-off.
    task automatic recv_vec(input string tag, input logic [63:0] w [LEN],
                            input logic [15:0] m, input int idx, input bit bp);
        int k = 0;
        int c = 0;
        while (k < LEN && c < 200) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_data   = 64'hDEAD_BEEF_0BAD_F00D;
            out_ready = bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
            chk($sformatf("%s.out_valid[%0d]", tag, k), 64'(out_valid), 64'd1);
            chk($sformatf("%s.in_ready[%0d]", tag, k),  64'(in_ready),  64'd0);
            chk($sformatf("%s.data[%0d]", tag, k),      out_data,       w[k]);
            chk($sformatf("%s.max[%0d]", tag, k),       out_max,        {4{m}});
            chk($sformatf("%s.last[%0d]", tag, k),      64'(out_last),  64'(k == LEN - 1));
`ifdef VEC_MAX_BCAST_ARGMAX_EN
            chk($sformatf("%s.idx[%0d]", tag, k),       64'(out_idx),   64'(idx));
`endif
            if (out_ready) k++;
            c++;
        end
        checks++;
        assert (k == LEN) else begin
            errors++;
            $error("FAIL %s.timeout observed=%0d expected=%0d words", tag, k, LEN);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk_idle({tag, ".rearm"});
    endtask

    logic [63:0] va [LEN];
    logic [63:0] vb [LEN];
    logic [63:0] vc [LEN];

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;

        // ascending 0..31
        for (int i = 0; i < LEN; i++)
            va[i] = mk(16'(4*i+3), 16'(4*i+2), 16'(4*i+1), 16'(4*i));
        send_vec("asc", va);
        recv_vec("asc", va, 16'h001F, 31, 1'b0);

        // all-negative with a single -1, drained under backpressure
        for (int i = 0; i < LEN; i++) va[i] = {4{16'h8000}};
        va[5] = mk(16'h8000, 16'hFFFF, 16'h8000, 16'h8000);
        send_vec("neg", va);
        recv_vec("neg", va, 16'hFFFF, 22, 1'b1);

        // ties: word1 lane3 and word6 lane0
        for (int i = 0; i < LEN; i++) va[i] = {4{16'h0050}};
        va[1] = mk(16'h0100, 16'h0050, 16'h0050, 16'h0050);
        va[6] = mk(16'h0050, 16'h0050, 16'h0050, 16'h0100);
        send_vec("tie", va);
        recv_vec("tie", va, 16'h0100, 7, 1'b0);

        // mid-vector reset after 3 transfers
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = {4{16'h7FFF}};
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle("midrst");
        for (int i = 0; i < LEN; i++)
            vc[i] = mk(16'(i+16'h40), 16'(i+16'h30), 16'(i+16'h20), 16'(i+16'h10));
        vc[4] = mk(16'h0001, 16'h0002, 16'h7FFF, 16'h0003);
        send_vec("fresh", vc);
        recv_vec("fresh", vc, 16'h7FFF, 17, 1'b0);

        // back-to-back: A max 5, then B all negative with max -3
        for (int i = 0; i < LEN; i++)
            va[i] = mk(16'(i % 6), 16'h0000, 16'hFFFE, 16'h0001);
        for (int i = 0; i < LEN; i++) vb[i] = {4{16'hFFF0}};
        vb[3] = mk(16'hFFF0, 16'hFFFD, 16'hFFF0, 16'hFFF0);
        send_vec("vecA", va);
        recv_vec("vecA", va, 16'h0005, 23, 1'b0);
        send_vec("vecB", vb);
        recv_vec("vecB", vb, 16'hFFFD, 14, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
